// File: rtl/swap_pkg.sv
// Shared state encoding and mode constants for the burst-swap engine.
package swap_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic MODE_SWAP = 1'b0;
  localparam logic MODE_COPY = 1'b1;

endpackage

// File: rtl/swap_burst_ctrl.sv
// Burst sequencer: one READ then one WRITE per word, remaining-word down-counter,
// phase strobes for the datapath in the top.
//
//   state | meaning
//   IDLE  | waiting for start; len captured on an accepted start
//   READ  | word addresses on raddr, read data captured at the edge
//   WRITE | captured data written back, addresses advance, count decrements
//   DONE  | one-cycle completion pulse
module swap_burst_ctrl
  import swap_pkg::*;
#(
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  output logic             accept,
  output logic             rd_phase,
  output logic             wr_phase,
  output logic             busy,
  output logic             done
);

  state_t           state, state_nxt;
  logic [LEN_W-1:0] remaining;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      remaining <= '0;
    end else begin
      state <= state_nxt;
      if (accept)
        remaining <= len;
      else if (wr_phase)
        remaining <= remaining - LEN_W'(1);
    end
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          // a zero-length request completes without touching memory
          if (len != '0) begin
            accept    = 1'b1;
            state_nxt = READ;
          end else begin
            state_nxt = DONE;
          end
        end
      end
      READ:    state_nxt = WRITE;
      WRITE:   state_nxt = (remaining > LEN_W'(1)) ? READ : DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // decoded straight from state so an async reset drops the strobes at once
  assign rd_phase = (state == READ);
  assign wr_phase = (state == WRITE);
  assign busy     = rd_phase | wr_phase;
  assign done     = (state == DONE);

endmodule

// File: rtl/swap_burst.sv
// Burst swap/copy engine between two memory ports; holds word addresses, the
// captured read data and the mode, with sequencing in swap_burst_ctrl.
module swap_burst
  import swap_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 8,
  parameter int LEN_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              mode,
  input  logic [ADDR_W-1:0] addra,
  input  logic [ADDR_W-1:0] addrb,
  input  logic [LEN_W-1:0]  len,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] mem_a_raddr,
  input  logic [DATA_W-1:0] mem_a_rdata,
  output logic [ADDR_W-1:0] mem_a_waddr,
  output logic [DATA_W-1:0] mem_a_wdata,
  output logic              mem_a_wen,
  output logic [ADDR_W-1:0] mem_b_raddr,
  input  logic [DATA_W-1:0] mem_b_rdata,
  output logic [ADDR_W-1:0] mem_b_waddr,
  output logic [DATA_W-1:0] mem_b_wdata,
  output logic              mem_b_wen
);

  logic              accept, rd_phase, wr_phase;
  logic [ADDR_W-1:0] addr_a, addr_b;
  logic [DATA_W-1:0] data_a, data_b;
  logic              mode_q;

  swap_burst_ctrl #(.LEN_W(LEN_W)) u_ctrl (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .len      (len),
    .accept   (accept),
    .rd_phase (rd_phase),
    .wr_phase (wr_phase),
    .busy     (busy),
    .done     (done)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_a <= '0;
      addr_b <= '0;
      data_a <= '0;
      data_b <= '0;
      mode_q <= MODE_SWAP;
    end else begin
      if (accept) begin
        addr_a <= addra;
        addr_b <= addrb;
        mode_q <= mode;
      end
      if (rd_phase) begin
        data_a <= mem_a_rdata;
        data_b <= mem_b_rdata;
      end
      // addresses wrap modulo 2^ADDR_W without notice
      if (wr_phase) begin
        addr_a <= addr_a + ADDR_W'(1);
        addr_b <= addr_b + ADDR_W'(1);
      end
    end
  end

  assign mem_a_raddr = addr_a;
  assign mem_b_raddr = addr_b;
  assign mem_a_waddr = addr_a;
  assign mem_b_waddr = addr_b;
  assign mem_a_wdata = data_b;
  assign mem_b_wdata = data_a;
  assign mem_a_wen   = wr_phase && (mode_q == MODE_SWAP);
  assign mem_b_wen   = wr_phase;

endmodule

// File: tb/tb_swap_burst.sv
// Scoreboard bench for swap_burst: expected writes queued at start, checked as
// the DUT writes; latency, busy span, final memory contents and reset behaviour.
module tb_swap_burst;
  import swap_pkg::*;

  localparam int AW = 32;
  localparam int DW = 8;
  localparam int LW = 8;

  logic          clk;
  logic          rst;
  logic          start;
  logic          mode;
  logic [AW-1:0] addra, addrb;
  logic [LW-1:0] len;
  logic          busy, done;
  logic [AW-1:0] mem_a_raddr, mem_a_waddr, mem_b_raddr, mem_b_waddr;
  logic [DW-1:0] mem_a_rdata, mem_a_wdata, mem_b_rdata, mem_b_wdata;
  logic          mem_a_wen, mem_b_wen;

  logic [DW-1:0] mem_a [4096];
  logic [DW-1:0] mem_b [4096];
  logic [DW-1:0] ref_a [4096];
  logic [DW-1:0] ref_b [4096];

  logic          pre_en;
  logic [AW-1:0] pre_aa, pre_ab;
  logic [DW-1:0] pre_da, pre_db;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  wr_t exp_a[$];
  wr_t exp_b[$];

  int n_checks = 0;
  int n_errors = 0;

  swap_burst #(.ADDR_W(AW), .DATA_W(DW), .LEN_W(LW)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .mode        (mode),
    .addra       (addra),
    .addrb       (addrb),
    .len         (len),
    .busy        (busy),
    .done        (done),
    .mem_a_raddr (mem_a_raddr),
    .mem_a_rdata (mem_a_rdata),
    .mem_a_waddr (mem_a_waddr),
    .mem_a_wdata (mem_a_wdata),
    .mem_a_wen   (mem_a_wen),
    .mem_b_raddr (mem_b_raddr),
    .mem_b_rdata (mem_b_rdata),
    .mem_b_waddr (mem_b_waddr),
    .mem_b_wdata (mem_b_wdata),
    .mem_b_wen   (mem_b_wen)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign mem_a_rdata = mem_a[mem_a_raddr[11:0]];
  assign mem_b_rdata = mem_b[mem_b_raddr[11:0]];

  always @(posedge clk) begin
    if (mem_a_wen) mem_a[mem_a_waddr[11:0]] <= mem_a_wdata;
    if (mem_b_wen) mem_b[mem_b_waddr[11:0]] <= mem_b_wdata;
    if (pre_en) begin
      mem_a[pre_aa[11:0]] <= pre_da;
      mem_b[pre_ab[11:0]] <= pre_db;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    wr_t e;
    if (mem_a_wen) begin
      if (exp_a.size() == 0) check("a_unexpected_wen", 32'd1, 32'd0);
      else begin
        e = exp_a.pop_front();
        check("a_waddr", mem_a_waddr, e.addr);
        check("a_wdata", 32'(mem_a_wdata), 32'(e.data));
      end
    end
    if (mem_b_wen) begin
      if (exp_b.size() == 0) check("b_unexpected_wen", 32'd1, 32'd0);
      else begin
        e = exp_b.pop_front();
        check("b_waddr", mem_b_waddr, e.addr);
        check("b_wdata", 32'(mem_b_wdata), 32'(e.data));
      end
    end
  end

  task automatic preload(input logic [AW-1:0] aa, input logic [AW-1:0] ab,
                         input logic [DW-1:0] da, input logic [DW-1:0] db);
    pre_en = 1'b1; pre_aa = aa; pre_ab = ab; pre_da = da; pre_db = db;
    ref_a[aa[11:0]] = da;
    ref_b[ab[11:0]] = db;
    @(posedge clk) #1;
    pre_en = 1'b0;
  endtask

  // word-by-word reference: each word sees the writes of the words before it
  task automatic push_burst(input logic m, input logic [AW-1:0] aa, input logic [AW-1:0] ab,
                            input logic [LW-1:0] n);
    logic [AW-1:0] a, b;
    logic [DW-1:0] va, vb;
    for (int i = 0; i < int'(n); i++) begin
      a  = aa + AW'(i);
      b  = ab + AW'(i);
      va = ref_a[a[11:0]];
      vb = ref_b[b[11:0]];
      if (m == MODE_SWAP) begin
        exp_a.push_back('{addr: a, data: vb});
        ref_a[a[11:0]] = vb;
      end
      exp_b.push_back('{addr: b, data: va});
      ref_b[b[11:0]] = va;
    end
  endtask

  task automatic run_burst(input logic m, input logic [AW-1:0] aa, input logic [AW-1:0] ab,
                           input logic [LW-1:0] n, input bit poke_start);
    int cyc, busy_cnt, done_at;
    start = 1'b1; mode = m; addra = aa; addrb = ab; len = n;
    push_burst(m, aa, ab, n);
    @(posedge clk) #1;
    start = 1'b0;
    cyc = 1; busy_cnt = 0; done_at = 0;
    while (cyc < 600) begin
      if (busy) busy_cnt++;
      if (done) begin
        done_at = cyc;
        break;
      end
      if (poke_start && cyc == 3) begin
        start = 1'b1; mode = ~m; addra = aa + 32'h40; addrb = ab + 32'h40; len = 8'd3;
      end else begin
        start = 1'b0;
      end
      @(posedge clk) #1;
      cyc++;
    end
    start = 1'b0;
    check("done_latency", 32'(done_at), 32'(2 * int'(n) + 1));
    check("busy_cycles", 32'(busy_cnt), 32'(2 * int'(n)));
    @(posedge clk) #1;
    check("done_pulse_width", {31'd0, done}, 32'd0);
    check("queues_drained", 32'(exp_a.size() + exp_b.size()), 32'd0);
  endtask

  task automatic cmp_range(input logic [AW-1:0] aa, input logic [AW-1:0] ab, input int n);
    logic [AW-1:0] a, b;
    for (int i = 0; i < n; i++) begin
      a = aa + AW'(i);
      b = ab + AW'(i);
      check("mem_a_final", 32'(mem_a[a[11:0]]), 32'(ref_a[a[11:0]]));
      check("mem_b_final", 32'(mem_b[b[11:0]]), 32'(ref_b[b[11:0]]));
    end
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; mode = 1'b0; addra = '0; addrb = '0; len = '0;
    pre_en = 1'b0; pre_aa = '0; pre_ab = '0; pre_da = '0; pre_db = '0;
    #3;
    check("reset_busy_done", {30'd0, busy, done}, 32'd0);
    check("reset_wen", {30'd0, mem_a_wen, mem_b_wen}, 32'd0);
    check("reset_addr", mem_a_raddr | mem_a_waddr | mem_b_raddr | mem_b_waddr, 32'd0);
    check("reset_wdata", {16'd0, mem_a_wdata, mem_b_wdata}, 32'd0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk) #1;

    // single-word swap
    preload(32'h10, 32'h20, 8'hAA, 8'h55);
    run_burst(MODE_SWAP, 32'h10, 32'h20, 8'd1, 1'b0);
    check("single_a", 32'(mem_a[12'h010]), 32'h55);
    check("single_b", 32'(mem_b[12'h020]), 32'hAA);

    // four-word swap
    for (int i = 0; i < 4; i++)
      preload(32'h100 + i, 32'h200 + i, 8'h11 + 8'(i), 8'h21 + 8'(i));
    run_burst(MODE_SWAP, 32'h100, 32'h200, 8'd4, 1'b0);
    cmp_range(32'h100, 32'h200, 4);
    check("burst_a3", 32'(mem_a[12'h103]), 32'h24);
    check("burst_b0", 32'(mem_b[12'h200]), 32'h11);

    // copy: A untouched, B takes A
    for (int i = 0; i < 3; i++)
      preload(32'h500 + i, 32'h600 + i, 8'h51 + 8'(i), 8'h61 + 8'(i));
    run_burst(MODE_COPY, 32'h500, 32'h600, 8'd3, 1'b0);
    cmp_range(32'h500, 32'h600, 3);
    check("copy_a_kept", 32'(mem_a[12'h502]), 32'h53);

    // zero length, then wrap past all-ones; back-to-back starts
    run_burst(MODE_SWAP, 32'h700, 32'h800, 8'd0, 1'b0);
    preload(32'hFFFF_FFFF, 32'h900, 8'hF1, 8'h91);
    preload(32'h0, 32'h901, 8'hF2, 8'h92);
    run_burst(MODE_SWAP, 32'hFFFF_FFFF, 32'h900, 8'd2, 1'b0);
    cmp_range(32'hFFFF_FFFF, 32'h900, 2);
    check("wrap_a0", 32'(mem_a[12'h000]), 32'h92);

    // start during a burst must be ignored
    for (int i = 0; i < 3; i++)
      preload(32'hA00 + i, 32'hB00 + i, 8'hA1 + 8'(i), 8'hB1 + 8'(i));
    run_burst(MODE_SWAP, 32'hA00, 32'hB00, 8'd3, 1'b1);
    cmp_range(32'hA00, 32'hB00, 3);

    // async reset in the WRITE of word 2
    for (int i = 0; i < 4; i++)
      preload(32'h300 + i, 32'h400 + i, 8'h31 + 8'(i), 8'h41 + 8'(i));
    start = 1'b1; mode = MODE_SWAP; addra = 32'h300; addrb = 32'h400; len = 8'd4;
    push_burst(MODE_SWAP, 32'h300, 32'h400, 8'd4);
    @(posedge clk) #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1 check("pre_reset_write", {31'd0, mem_a_wen}, 32'd1);
    #1 rst = 1'b0;
    #1;
    check("midrst_wen", {30'd0, mem_a_wen, mem_b_wen}, 32'd0);
    check("midrst_busy_done", {30'd0, busy, done}, 32'd0);
    check("midrst_addr", mem_a_raddr | mem_a_waddr | mem_b_raddr | mem_b_waddr, 32'd0);
    check("midrst_wdata", {16'd0, mem_a_wdata, mem_b_wdata}, 32'd0);
    exp_a.delete();
    exp_b.delete();
    for (int i = 1; i < 4; i++) begin
      ref_a[12'h300 + 12'(i)] = 8'h31 + 8'(i);
      ref_b[12'h400 + 12'(i)] = 8'h41 + 8'(i);
    end
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk) #1;
    cmp_range(32'h300, 32'h400, 4);
    check("rst_word1_swapped", 32'(mem_a[12'h300]), 32'h41);
    check("rst_word2_kept", 32'(mem_a[12'h301]), 32'h32);

    // normal operation after reset
    run_burst(MODE_SWAP, 32'h301, 32'h401, 8'd2, 1'b0);
    cmp_range(32'h300, 32'h400, 4);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/swap_burst.md
Name: swap_burst

Overview:
- Parametrised burst-swap engine for the vmem test fabric.
- Exchanges LEN consecutive words between two independent memory ports A and B, starting at addra/addrb.
- Optionally copies A→B instead of swapping.
- Same one-read-then-one-write per-word memory timing as the existing single-word swap; adds burst length, width parameters, mode select and a busy/done handshake.

Parameters:
- ADDR_W, 32, address width of both memory ports
- DATA_W, 8, data word width of both memory ports
- LEN_W, 8, width of the burst-length input; max burst = 2^LEN_W-1 words

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- start  in  1  request pulse; sampled only in IDLE
- mode  in  1  0 = swap A↔B, 1 = copy A→B; captured with start
- addra  in  ADDR_W  base address on port A; captured with start
- addrb  in  ADDR_W  base address on port B; captured with start
- len  in  LEN_W  word count; captured with start
- busy  out  1  high from the cycle after an accepted start until done is asserted
- done  out  1  one-cycle completion pulse
- mem_a_raddr  out  ADDR_W  port A read address
- mem_a_rdata  in  DATA_W  port A read data, valid combinationally for current raddr
- mem_a_waddr  out  ADDR_W  port A write address
- mem_a_wdata  out  DATA_W  port A write data
- mem_a_wen  out  1  port A write enable
- mem_b_raddr / mem_b_rdata / mem_b_waddr / mem_b_wdata / mem_b_wen: same as port A, for port B

Behaviour:
- States: IDLE, READ, WRITE, DONE.
- While rst=0, immediately force: state=IDLE; address regs, data regs and remaining count =0.
- Outputs under reset: busy=0, done=0, both wen=0, all addresses/wdata=0.
- IDLE, start=1, len≠0:
  - Capture addra, addrb, len, mode.
  - Next state READ.
- IDLE, start=1, len=0: go to DONE; no memory writes.
- IDLE, start=0: stay.
- READ (1 cycle):
  - raddr = current word addresses.
  - Capture mem_a_rdata and mem_b_rdata at the clock edge.
  - Next state WRITE.
- WRITE (1 cycle), waddr = current word addresses:
  - swap: mem_a_wdata = captured B, mem_b_wdata = captured A, both wen=1.
  - copy: mem_b_wdata = captured A, mem_b_wen=1, mem_a_wen=0.
  - At the edge, both addresses increment by 1 and the remaining count decrements.
  - Next state READ if remaining >1, else DONE.
- DONE (1 cycle): done=1, then IDLE.
- busy=1 in READ and WRITE; busy=0 in DONE. Start is only sampled in IDLE, so any start outside IDLE is ignored, not queued.
- Latency: accepted start → done high = 2·len+1 cycles; len=0 gives 1 cycle.
- wen is decoded combinationally from state; reset assertion mid-burst drops wen in the same cycle. Words already written stay written; there is no rollback.
- Address arithmetic is modulo 2^ADDR_W. Increment past all-ones wraps to 0 silently.
- addra==addrb in swap mode: both ports are still written; memories remain consistent. No special case.
- Overlapping ranges within one port space are the caller's responsibility: reads always see the prior word's writes.
- wdata and waddr hold their last values outside WRITE; only wen qualifies them.
- start is back-to-back capable: start in the IDLE cycle right after DONE is accepted.

Decomposition:
- Shared package swap_pkg: state encoding constants (IDLE=0, READ=1, WRITE=2, DONE=3) and mode constants MODE_SWAP=0, MODE_COPY=1.
- One natural sub-module: swap_burst_ctrl (FSM + remaining-length counter, outputs phase strobes).
- Address/data registers stay in the top.

Test Plan:
- Single swap, mode=0: A[0x10]=0xAA, B[0x20]=0x55, len=1 → one WRITE cycle with a_wdata=0x55, b_wdata=0xAA; done 3 cycles after start; A[0x10]=0x55, B[0x20]=0xAA.
- Burst swap, len=4, addra=0x100, addrb=0x200, A=11..14, B=21..24 → four write cycles at 0x100..0x103 / 0x200..0x203; final A=21..24, B=11..14; done at cycle 9; busy high cycles 1–8.
- Copy mode, len=3 → mem_a_wen never asserted; B[base..base+2] = A values; A unchanged.
- len=0 and wrap: len=0 → done 1 cycle after start, no wen. Then addra=0xFFFFFFFF, len=2 → second word at address 0x0.
- Start ignored while busy: start pulsed mid-burst with different addresses → no effect; only the original burst executes.
- Async reset during WRITE of word 2 of len=4 → wen drops before the next edge; busy=0, all outputs 0; word 1 swapped, words 2–4 untouched. Start after reset release → works normally.
